uart_tx_frame_controller: RTL and testbench

Sequences one UART transmit frame per accepted byte: start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits. Generates the bit timing internally from a programmable clock divider and the oversampling rate. Can inject parity, framing and break errors for negative testing. Sits between the TX data source, using a valid/ready handshake, and the serial txd pin.

---
 rtl/uart_tx_frame_controller_pkg.sv | 56 +++++
 rtl/uart_baud_tick_gen.sv | 31 +++
 rtl/uart_tx_frame_controller.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_frame_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_controller_pkg.sv
// Shared UART definitions: data width, line levels, configuration enums,
// transmitter state encoding and the frame parity helper.
package uart_tx_frame_controller_pkg;

   localparam int DATA_WIDTH = 8;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1} UartParityEnum;

   typedef enum logic [1:0] {STOP_1 = 2'd1, STOP_2 = 2'd2} UartStopEnum;

   typedef enum logic [4:0] {OS_13 = 5'd13, OS_16 = 5'd16} UartOversampleEnum;

   typedef enum logic [3:0] {
      DATA_5 = 4'd5, DATA_6 = 4'd6, DATA_7 = 4'd7, DATA_8 = 4'd8
   } UartDataTypeEnum;

   typedef enum logic [3:0] {
      RESET          = 4'd0,
      IDLE           = 4'd1,
      STARTBIT       = 4'd2,
      BIT0           = 4'd3,
      BIT1           = 4'd4,
      BIT2           = 4'd5,
      BIT3           = 4'd6,
      BIT4           = 4'd7,
      BIT5           = 4'd8,
      BIT6           = 4'd9,
      BIT7           = 4'd10,
      PARITYBIT      = 4'd11,
      STOPBIT        = 4'd12,
      INVALIDSTOPBIT = 4'd13
   } UartTransmitterStateEnum;

   // Out-of-range data widths fall back to a full byte.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] dt);
      return ((dt >= DATA_5) && (dt <= DATA_8)) ? dt : DATA_8;
   endfunction

   function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic [3:0] nbits,
                                         input logic odd,
                                         input logic inject);
      logic p;
      p = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (4'(i) < nbits) begin
            p = p ^ data[i];
         end
      end
      return p ^ odd ^ inject;
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: pulses tick once every max(divisor,1) clk cycles.
module uart_baud_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] r_tickCnt;
   logic [DIV_WIDTH-1:0] w_divLast;

   // A zero divisor behaves like a divisor of one.
   assign w_divLast = (divisor == {DIV_WIDTH{1'b0}}) ? {DIV_WIDTH{1'b0}}
                    : divisor - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   assign tick      = (r_tickCnt == w_divLast);

   // Divider count, restarted by the controller on every bit boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tickCnt <= {DIV_WIDTH{1'b0}};
      end else if (clear || tick) begin
         r_tickCnt <= {DIV_WIDTH{1'b0}};
      end else begin
         r_tickCnt <= r_tickCnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer with error injection.
// Optional frameCount output enabled by defining UART_TX_FRAME_COUNT_EN.
module uart_tx_frame_controller
   import uart_tx_frame_controller_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   txData,
   input  logic                    txValid,
   output logic                    txReady,
   input  logic [3:0]              dataType,
   input  logic                    parityEnable,
   input  logic                    parityType,
   input  logic [1:0]              stopBits,
   input  logic [4:0]              overSampling,
   input  logic [DIV_WIDTH-1:0]    baudDivisor,
   input  logic                    parityErrInj,
   input  logic                    framingErrInj,
   input  logic                    breakErrInj,
   output logic                    txd,
   output UartTransmitterStateEnum state,
   output logic                    frameDone
`ifdef UART_TX_FRAME_COUNT_EN
   ,output logic [15:0]            frameCount
`endif
);

   UartTransmitterStateEnum r_state;
   logic                  r_txd, r_txReady, r_frameDone;
   logic [4:0]            r_sampleCnt, r_os;
   logic [2:0]            r_bitIdx;
   logic                  r_stopCnt, r_twoStop, r_parEn, r_parity, r_framErr, r_break;
   logic [DATA_WIDTH-1:0] r_data;
   logic [3:0]            r_nbits;
   logic [DIV_WIDTH-1:0]  r_div;

   logic w_tick, w_accept, w_inFrame, w_inStop, w_bitEnd, w_lastStop;
   logic w_lastData, w_stateChange, w_clear, w_frameEnd;
   UartTransmitterStateEnum w_stopState;

   assign w_accept      = (r_state == IDLE) && r_txReady && txValid;
   assign w_inFrame     = (r_state != RESET) && (r_state != IDLE);
   assign w_inStop      = (r_state == STOPBIT) || (r_state == INVALIDSTOPBIT);
   assign w_bitEnd      = w_inFrame && w_tick && (r_sampleCnt == (r_os - 5'd1));
   assign w_lastStop    = (r_stopCnt == r_twoStop);
   assign w_lastData    = ({1'b0, r_bitIdx} == (r_nbits - 4'd1));
   assign w_frameEnd    = w_inStop && w_bitEnd && w_lastStop;
   // The only bit end without a state change is between two stop bits.
   assign w_stateChange = w_bitEnd && !(w_inStop && !w_lastStop);
   assign w_clear       = !w_inFrame || w_accept || w_stateChange;
   assign w_stopState   = r_framErr ? INVALIDSTOPBIT : STOPBIT;

   uart_baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .divisor (r_div),
      .tick    (w_tick)
   );

   // Oversample counter within the current bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sampleCnt <= 5'd0;
      end else if (w_clear) begin
         r_sampleCnt <= 5'd0;
      end else if (w_tick) begin
         r_sampleCnt <= w_bitEnd ? 5'd0 : r_sampleCnt + 5'd1;
      end else begin
         r_sampleCnt <= r_sampleCnt;
      end
   end

   // Frame state machine with registered line, handshake and done outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RESET;
         r_txd       <= STOP_BIT;
         r_txReady   <= 1'b0;
         r_frameDone <= 1'b0;
         r_bitIdx    <= 3'd0;
         r_stopCnt   <= 1'b0;
         r_data      <= {DATA_WIDTH{1'b0}};
         r_nbits     <= 4'd8;
         r_parEn     <= 1'b0;
         r_parity    <= 1'b0;
         r_twoStop   <= 1'b0;
         r_os        <= 5'd16;
         r_div       <= {DIV_WIDTH{1'b0}};
         r_framErr   <= 1'b0;
         r_break     <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         case (r_state)
            RESET: begin
               r_state   <= IDLE;
               r_txReady <= 1'b1;
               r_txd     <= STOP_BIT;
            end
            IDLE: begin
               r_txd <= STOP_BIT;
               if (w_accept) begin
                  r_state   <= STARTBIT;
                  r_txd     <= START_BIT;
                  r_txReady <= 1'b0;
                  r_bitIdx  <= 3'd0;
                  r_stopCnt <= 1'b0;
                  r_data    <= txData;
                  r_nbits   <= clamp_data_bits(dataType);
                  r_parEn   <= parityEnable;
                  r_parity  <= frame_parity(txData, clamp_data_bits(dataType),
                                            parityType == PARITY_ODD, parityErrInj);
                  r_twoStop <= (stopBits == STOP_2);
                  r_os      <= (overSampling == OS_13) ? 5'd13 : 5'd16;
                  r_div     <= baudDivisor;
                  r_framErr <= framingErrInj;
                  r_break   <= breakErrInj;
               end else begin
                  r_txReady <= 1'b1;
               end
            end
            STARTBIT: begin
               if (w_bitEnd) begin
                  r_state <= BIT0;
                  r_txd   <= !r_break && r_data[0];
               end else begin
                  r_state <= r_state;
               end
            end
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
               if (w_bitEnd && w_lastData && r_parEn) begin
                  r_state <= PARITYBIT;
                  r_txd   <= !r_break && r_parity;
               end else if (w_bitEnd && w_lastData) begin
                  r_state <= w_stopState;
                  r_txd   <= !r_break && !r_framErr;
               end else if (w_bitEnd) begin
                  r_state  <= UartTransmitterStateEnum'(r_state + 4'd1);
                  r_bitIdx <= r_bitIdx + 3'd1;
                  r_txd    <= !r_break && r_data[r_bitIdx + 3'd1];
               end else begin
                  r_state <= r_state;
               end
            end
            PARITYBIT: begin
               if (w_bitEnd) begin
                  r_state <= w_stopState;
                  r_txd   <= !r_break && !r_framErr;
               end else begin
                  r_state <= r_state;
               end
            end
            STOPBIT, INVALIDSTOPBIT: begin
               if (w_frameEnd) begin
                  r_state     <= IDLE;
                  r_txd       <= STOP_BIT;
                  r_frameDone <= 1'b1;
                  r_txReady   <= 1'b0;
               end else if (w_bitEnd) begin
                  r_stopCnt <= 1'b1;
               end else begin
                  r_stopCnt <= r_stopCnt;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_txd     <= STOP_BIT;
               r_txReady <= 1'b0;
            end
         endcase
      end
   end

   assign txd       = r_txd;
   assign txReady   = r_txReady;
   assign state     = r_state;
   assign frameDone = r_frameDone;

`ifdef UART_TX_FRAME_COUNT_EN
   logic [15:0] r_frameCount;

   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frameCount <= 16'd0;
      end else if (w_frameEnd) begin
         r_frameCount <= r_frameCount + 16'd1;
      end else begin
         r_frameCount <= r_frameCount;
      end
   end

   assign frameCount = r_frameCount;
`endif

endmodule

// File: tb/tb_uart_tx_frame_controller.sv
// Self-checking bench for uart_tx_frame_controller: directed frames plus
// randomized frames compared against a bit-list reference model.
module tb_uart_tx_frame_controller;
   import uart_tx_frame_controller_pkg::*;

   typedef struct {
      logic [7:0]  data;
      logic [3:0]  dtype;
      logic        pen;
      logic        ptype;
      logic [1:0]  stop;
      logic [4:0]  os;
      logic [15:0] div;
      logic        perr;
      logic        ferr;
      logic        brk;
   } cfg_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [3:0]  dataType;
   logic        parityEnable;
   logic        parityType;
   logic [1:0]  stopBits;
   logic [4:0]  overSampling;
   logic [15:0] baudDivisor;
   logic        parityErrInj;
   logic        framingErrInj;
   logic        breakErrInj;
   logic        txd;
   logic        frameDone;
   UartTransmitterStateEnum state_w;

   int n_checks = 0;
   int n_fail   = 0;

   UartTransmitterStateEnum bit_st [8] = '{BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7};

   uart_tx_frame_controller dut (
      .clk           (clk),
      .reset         (reset),
      .txData        (txData),
      .txValid       (txValid),
      .txReady       (txReady),
      .dataType      (dataType),
      .parityEnable  (parityEnable),
      .parityType    (parityType),
      .stopBits      (stopBits),
      .overSampling  (overSampling),
      .baudDivisor   (baudDivisor),
      .parityErrInj  (parityErrInj),
      .framingErrInj (framingErrInj),
      .breakErrInj   (breakErrInj),
      .txd           (txd),
      .state         (state_w),
      .frameDone     (frameDone)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic cfg_t mk(input logic [7:0] data, input logic [3:0] dtype,
                               input logic pen, input logic ptype, input logic [1:0] stop,
                               input logic [4:0] os, input logic [15:0] div,
                               input logic perr, input logic ferr, input logic brk);
      cfg_t c;
      c.data = data; c.dtype = dtype; c.pen = pen; c.ptype = ptype; c.stop = stop;
      c.os = os; c.div = div; c.perr = perr; c.ferr = ferr; c.brk = brk;
      return c;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.data  = 8'($urandom);
      c.dtype = 4'($urandom_range(0, 15));
      c.pen   = 1'($urandom);
      c.ptype = 1'($urandom);
      c.stop  = 2'($urandom);
      case ($urandom_range(0, 3))
         0:       c.os = 5'd13;
         1:       c.os = 5'd16;
         2:       c.os = 5'($urandom_range(0, 31));
         default: c.os = 5'd16;
      endcase
      c.div  = 16'($urandom_range(0, 3));
      c.perr = ($urandom_range(0, 3) == 0);
      c.ferr = ($urandom_range(0, 3) == 0);
      c.brk  = ($urandom_range(0, 5) == 0);
      return c;
   endfunction

   task automatic drive_cfg(input cfg_t c);
      txData = c.data; dataType = c.dtype; parityEnable = c.pen; parityType = c.ptype;
      stopBits = c.stop; overSampling = c.os; baudDivisor = c.div;
      parityErrInj = c.perr; framingErrInj = c.ferr; breakErrInj = c.brk;
   endtask

   task automatic scramble_inputs();
      txValid = 1'b0;
      drive_cfg(rand_cfg());
   endtask

   // Waits (bounded) for txReady at a negedge, presents the byte, returns at
   // the negedge just after the accepting edge (first cycle of the frame).
   task automatic start_frame(input cfg_t c, input bit keep_valid);
      int k = 0;
      while (txReady !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_val("ready_before_send", 32'(txReady), 32'd1);
      drive_cfg(c);
      txValid = 1'b1;
      @(negedge clk);
      if (!keep_valid) txValid = 1'b0;
   endtask

   // Checks one whole frame from its first cycle through the frameDone cycle.
   task automatic run_frame(input cfg_t c);
      int d, o, n, per, total, nstop;
      bit p;
      bit bits[$];
      UartTransmitterStateEnum sts[$];
      d     = (c.div == 16'd0) ? 1 : int'(c.div);
      o     = (c.os == 5'd13 || c.os == 5'd16) ? int'(c.os) : 16;
      n     = (c.dtype >= 4'd5 && c.dtype <= 4'd8) ? int'(c.dtype) : 8;
      nstop = (c.stop == 2'd2) ? 2 : 1;
      bits.push_back(1'b0); sts.push_back(STARTBIT);
      p = c.ptype ^ c.perr;
      for (int k = 0; k < n; k++) begin
         bits.push_back(c.brk ? 1'b0 : c.data[k]);
         sts.push_back(bit_st[k]);
         p = p ^ c.data[k];
      end
      if (c.pen) begin
         bits.push_back(c.brk ? 1'b0 : p);
         sts.push_back(PARITYBIT);
      end
      for (int k = 0; k < nstop; k++) begin
         bits.push_back((c.brk || c.ferr) ? 1'b0 : 1'b1);
         sts.push_back(c.ferr ? INVALIDSTOPBIT : STOPBIT);
      end
      per   = d * o;
      total = bits.size() * per;
      for (int cyc = 0; cyc < total; cyc++) begin
         int b  = cyc / per;
         int ph = cyc % per;
         check_val("txd", 32'(txd), 32'(bits[b]));
         if (ph == 0) begin
            check_val("state", 32'(state_w), 32'(sts[b]));
            check_val("txReady_busy", 32'(txReady), 32'd0);
         end
         if (ph == per - 1) check_val("frameDone_early", 32'(frameDone), 32'd0);
         @(negedge clk);
      end
      check_val("frameDone", 32'(frameDone), 32'd1);
      check_val("state_end", 32'(state_w), 32'(IDLE));
      check_val("txd_end", 32'(txd), 32'd1);
      check_val("txReady_end", 32'(txReady), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_t c, c2;
      reset = 1'b1; txValid = 1'b0;
      drive_cfg(mk(8'h00, 4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0, 1'b0, 1'b0));
      repeat (3) @(negedge clk);
      check_val("rst_state", 32'(state_w), 32'(RESET));
      check_val("rst_txd", 32'(txd), 32'd1);
      check_val("rst_txReady", 32'(txReady), 32'd0);
      check_val("rst_frameDone", 32'(frameDone), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_val("idle_state", 32'(state_w), 32'(IDLE));
      check_val("idle_txReady", 32'(txReady), 32'd1);
      check_val("idle_txd", 32'(txd), 32'd1);

      c = mk(8'hA5, 4'd8, 1'b1, 1'b0, 2'd1, 5'd16, 16'd2, 1'b0, 1'b0, 1'b0);
      start_frame(c, 1'b0); scramble_inputs(); run_frame(c);
      c = mk(8'h13, 4'd5, 1'b1, 1'b1, 2'd1, 5'd13, 16'd1, 1'b0, 1'b0, 1'b0);
      start_frame(c, 1'b0); scramble_inputs(); run_frame(c);
      c = mk(8'hFF, 4'd8, 1'b0, 1'b0, 2'd2, 5'd16, 16'd1, 1'b0, 1'b1, 1'b0);
      start_frame(c, 1'b0); scramble_inputs(); run_frame(c);
      @(negedge clk);
      check_val("idle_after_ferr_txd", 32'(txd), 32'd1);
      c = mk(8'h00, 4'd8, 1'b1, 1'b0, 2'd1, 5'd16, 16'd1, 1'b1, 1'b0, 1'b1);
      start_frame(c, 1'b0); scramble_inputs(); run_frame(c);

      // Reset in the middle of BIT3 of an all-zero byte.
      c = mk(8'h00, 4'd8, 1'b0, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0, 1'b0, 1'b0);
      start_frame(c, 1'b0); scramble_inputs();
      repeat (69) @(negedge clk);
      check_val("bit3_state", 32'(state_w), 32'(BIT3));
      check_val("bit3_txd", 32'(txd), 32'd0);
      #2 reset = 1'b1;
      #1;
      check_val("midrst_txd", 32'(txd), 32'd1);
      check_val("midrst_state", 32'(state_w), 32'(RESET));
      check_val("midrst_frameDone", 32'(frameDone), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("postrst_state", 32'(state_w), 32'(IDLE));
      check_val("postrst_frameDone", 32'(frameDone), 32'd0);
      c = mk(8'h3C, 4'd8, 1'b1, 1'b0, 2'd1, 5'd16, 16'd1, 1'b0, 1'b0, 1'b0);
      start_frame(c, 1'b0); scramble_inputs(); run_frame(c);

      // Back-to-back with txValid held high.
      @(negedge clk);
      c  = mk(8'h01, 4'd8, 1'b0, 1'b0, 2'd1, 5'd13, 16'd1, 1'b0, 1'b0, 1'b0);
      c2 = c; c2.data = 8'h80;
      start_frame(c, 1'b1);
      txData = 8'h80;
      run_frame(c);
      @(negedge clk);
      check_val("b2b_gap_ready", 32'(txReady), 32'd1);
      check_val("b2b_gap_state", 32'(state_w), 32'(IDLE));
      @(negedge clk);
      check_val("b2b_second_start", 32'(state_w), 32'(STARTBIT));
      txValid = 1'b0;
      run_frame(c2);

      for (int i = 0; i < 25; i++) begin
         c = rand_cfg();
         start_frame(c, 1'b0); scramble_inputs(); run_frame(c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
